exe_sched_w1: RTL and testbench
===============================

# exe_sched_w1

Two-requester scheduler that shares a single `exe_unit_w1` execution unit. It accepts operation requests (`oper`, `argA`, `argB`) from two clients over valid/ready handshakes and arbitrates between them round-robin. It drives the execution unit's operand inputs, waits out the unit's fixed pipeline latency, and returns the captured result and status to the granted client. It sits between the client front-ends and the `exe_unit_w1` instance, which is instantiated beside it, not inside it.

## Interface
- `M`, 4, operand/result width; matches `exe_unit_w1.m`.
- `N`, 2, operation code width; matches `exe_unit_w1.n`.
- `LAT`, 1, execution unit latency: cycles from operands presented to `i_result`/`i_status` valid; legal range 1..15.

Ports:
- `i_clk`  in  1  clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_req_valid`  in  [1:0]  request valid, one bit per client.
- `o_req_ready`  out  [1:0]  request accepted this cycle, one-hot or zero.
- `i_req_oper`  in  [1:0][N-1:0]  per-client operation code.
- `i_req_argA`  in  [1:0][M-1:0]  per-client operand A (signed).
- `i_req_argB`  in  [1:0][M-1:0]  per-client operand B (signed).
- `o_rsp_valid`  out  [1:0]  response valid for a client, one-hot or zero.
- `i_rsp_ready`  in  [1:0]  client accepts the response.
- `o_rsp_result`  out  M  captured result.
- `o_rsp_status`  out  2  captured status.
- `o_oper`  out  N  operation code to the execution unit.
- `o_argA`  out  M  operand A to the execution unit.
- `o_argB`  out  M  operand B to the execution unit.
- `i_result`  in  M  execution unit result.
- `i_status`  in  2  execution unit status.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `o_req_ready[g]` is asserted combinationally for the selected client `g` only when `i_req_valid[g]`=1.
  - On the handshake, latch `oper`/`argA`/`argB` into the operand registers, record `g`, clear the latency counter, and go to EXEC.
  - No valid request: stay in IDLE.
- **Arbitration**
  - If exactly one client is valid, that client is granted.
  - If both are valid, grant the client that was not served last.
  - The `last` pointer resets to 1, so client 0 wins the first tie.
  - `last` updates only on response handshake.
- **EXEC**
  - `o_oper`/`o_argA`/`o_argB` come directly from the operand registers and are held stable for the whole state.
  - The counter increments every cycle.
  - When counter == `LAT`, capture `i_result`/`i_status` into the response registers and go to RESP.
- **RESP**
  - `o_rsp_valid[g]`=1; result and status are held stable.
  - On `i_rsp_ready[g]`=1: set `last`←`g` and go to IDLE.
  - `i_rsp_ready` of the non-granted client is ignored.
- **Protocol rules**
  - Clients must hold `i_req_valid` and their payload stable until ready.
  - Payload changes before the handshake are not checked.
  - No new request is accepted while busy: single outstanding operation.
- **Widths**
  - Operands and result pass through unmodified.
  - No sign extension and no arithmetic in this block.

## Timing
- **Reset values**
  - State=IDLE, `last`=1, counter=0.
  - `o_oper`, `o_argA`, `o_argB`, `o_rsp_result`, `o_rsp_status` = 0.
  - `o_req_ready`, `o_rsp_valid` = 0; `o_busy`=0.
- **Latency:** handshake in cycle t → operands on the execution unit ports from t+1 → capture at the end of cycle t+1+LAT → `o_rsp_valid` from t+2+LAT.
  - With `LAT`=1 the response is first visible 3 cycles after acceptance.
- **Throughput:** the earliest next acceptance is the cycle after the response handshake. The IDLE bubble is mandatory.
- **Reset mid-operation:** an asynchronous assert in EXEC or RESP aborts immediately, with no response. All outputs take their reset values within the same cycle.
- **Response stall:** if the client never asserts ready, the block stays in RESP indefinitely. The other client is starved by design and there is no timeout.
- **Simultaneous events:** a request arriving while in RESP from the client being answered is accepted no earlier than the next IDLE cycle.

## Structure
- Package `exe_sched_pkg`:
  - `sched_state_t` enum {IDLE, EXEC, RESP}.
  - Default widths `M_DEF`=4, `N_DEF`=2, `LAT_DEF`=1.
  - Counter width constant `LAT_CW`=4.
- Sub-module `exe_sched_rr2`: combinational 2-way round-robin picker. Inputs are valid[1:0] and `last`; outputs are a one-hot grant.
- Top-level `exe_sched_w1` holds the FSM, counter, operand registers and response registers.

## Test plan
- **Bench setup:** M=4, N=2, LAT=1, with a stub execution unit that registers result=argA^argB and status=oper.
- **Reset:** assert `i_rst` → all outputs 0, `o_busy`=0.
- **Single request:** client 0 sends oper=2, A=4'b1111, B=4'b1101 at t → `o_argA`/`o_argB` = F/D from t+1; `o_rsp_valid`=2'b01 at t+3 with result=4'b0010, status=2'b10.
- **Tie:**
  - Both clients valid out of reset → client 0 granted first; client 1 accepted in the first IDLE after client 0's response handshake.
  - Both remain valid for two more rounds → grants alternate 1, 0.
- **Response backpressure:** hold `i_rsp_ready`=0 for 5 cycles → result and status held stable, `o_req_ready` stays 0, `o_busy`=1. Then ready=1 → IDLE next cycle.
- **Mid-operation reset:** assert `i_rst` in EXEC with LAT=3 → no `o_rsp_valid` ever; after release, a client 1 request completes normally and client 0 still wins the next tie.
- **Latency sweep:** repeat the single-request scenario with LAT=4 → response at t+6; operands stable on the execution unit ports t+1..t+5.

Source files
------------

// File: rtl/exe_sched_w1_pkg.sv
// -----------------------------------------------------------------------------
// exe_sched_pkg
// Shared types and constants for the two-client execution-unit scheduler.
//   sched_state_t : scheduler FSM state encoding (IDLE, EXEC, RESP)
//   M_DEF/N_DEF   : default operand/result and operation-code widths
//   LAT_DEF       : default execution-unit latency in cycles
//   LAT_CW        : width of the latency counter (covers latencies 1..15)
//   idx_to_onehot : maps a client index to its one-hot handshake vector
// -----------------------------------------------------------------------------
package exe_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int M_DEF   = 4;
    localparam int N_DEF   = 2;
    localparam int LAT_DEF = 1;
    localparam int LAT_CW  = 4;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/exe_sched_w1_if.sv
// -----------------------------------------------------------------------------
// exe_sched_w1_if
// Bundles the client request/response handshakes and the execution-unit
// operand/result bus seen by the scheduler.
//   req_valid/req_ready      : per-client request handshake ([1:0])
//   req_oper/req_arg_a/_b    : per-client request payload
//   rsp_valid/rsp_ready      : per-client response handshake ([1:0])
//   rsp_result/rsp_status    : shared response payload
//   oper/arg_a/arg_b         : operands driven to the execution unit
//   result/status            : execution-unit outputs
//   busy                     : scheduler not idle
// Modports: slave = scheduler side, master = clients plus execution unit.
// -----------------------------------------------------------------------------
interface exe_sched_w1_if
    import exe_sched_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF
) ();

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0][N-1:0]   req_oper;
    logic [1:0][M-1:0]   req_arg_a;
    logic [1:0][M-1:0]   req_arg_b;

    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [M-1:0]        rsp_result;
    logic [1:0]          rsp_status;

    logic [N-1:0]        oper;
    logic [M-1:0]        arg_a;
    logic [M-1:0]        arg_b;
    logic [M-1:0]        result;
    logic [1:0]          status;

    logic                busy;

    modport slave (
        input  req_valid, req_oper, req_arg_a, req_arg_b,
        input  rsp_ready, result, status,
        output req_ready, rsp_valid, rsp_result, rsp_status,
        output oper, arg_a, arg_b, busy
    );

    modport master (
        output req_valid, req_oper, req_arg_a, req_arg_b,
        output rsp_ready, result, status,
        input  req_ready, rsp_valid, rsp_result, rsp_status,
        input  oper, arg_a, arg_b, busy
    );

endinterface

// File: rtl/exe_sched_w1_rr2.sv
// -----------------------------------------------------------------------------
// exe_sched_rr2
// Combinational two-way round-robin picker.
//   valid[1:0] : in,  requesting clients
//   last       : in,  index of the client served most recently
//   grant[1:0] : out, one-hot grant (zero when nobody requests)
// A lone requester always wins; on a tie the client that was not served
// last wins.
// -----------------------------------------------------------------------------
module exe_sched_rr2
    import exe_sched_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = idx_to_onehot(~last);
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/exe_sched_w1.sv
// -----------------------------------------------------------------------------
// exe_sched_w1
// Shares one exe_unit_w1 between two clients. A request is accepted in IDLE,
// its operands are held on the execution-unit bus for LAT+1 cycles (EXEC),
// the unit output is captured when the counter reaches LAT, and the result is
// presented to the granted client until it takes it (RESP).
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : exe_sched_w1_if.slave (client handshakes + execution-unit bus)
// Parameters: M operand width, N opcode width, LAT unit latency (1..15).
// -----------------------------------------------------------------------------
module exe_sched_w1
    import exe_sched_pkg::*;
#(
    parameter int M   = M_DEF,
    parameter int N   = N_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    exe_sched_w1_if.slave bus
);

    localparam logic [LAT_CW-1:0] LAT_V = LAT_CW'(LAT);
    localparam logic [LAT_CW-1:0] ONE_V = LAT_CW'(1);

    sched_state_t        state;
    sched_state_t        state_nx;

    logic                last;
    logic                gsel;
    logic [LAT_CW-1:0]   cnt;
    logic [1:0]          grant;
    logic [1:0]          req_ready;
    logic                accept;
    logic                cnt_hit;
    logic                rsp_take;

    logic [N-1:0]        oper_r;
    logic signed [M-1:0] arg_a_r;
    logic signed [M-1:0] arg_b_r;
    logic [M-1:0]        result_r;
    logic [1:0]          status_r;

    exe_sched_rr2 u_rr2 (
        .valid (bus.req_valid),
        .last  (last),
        .grant (grant)
    );

    // Grant is already qualified by valid, so any grant in IDLE is a handshake.
    assign accept   = (state == IDLE) && (grant != 2'b00);
    assign cnt_hit  = (state == EXEC) && (cnt == LAT_V);
    // Only the granted client's ready matters; the other bit is ignored.
    assign rsp_take = (state == RESP) && bus.rsp_ready[gsel];

    always_comb begin
        state_nx  = state;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (accept) state_nx = EXEC;
            end
            EXEC: begin
                if (cnt_hit) state_nx = RESP;
            end
            RESP: begin
                if (rsp_take) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last     <= 1'b1;
            gsel     <= 1'b0;
            cnt      <= '0;
            oper_r   <= '0;
            arg_a_r  <= '0;
            arg_b_r  <= '0;
            result_r <= '0;
            status_r <= '0;
        end else begin
            if (accept) begin
                gsel    <= grant[1];
                oper_r  <= bus.req_oper[grant[1]];
                arg_a_r <= bus.req_arg_a[grant[1]];
                arg_b_r <= bus.req_arg_b[grant[1]];
                cnt     <= '0;
            end
            // Counter runs through the whole EXEC state; it is cleared on
            // the next acceptance, so its value after the capture is unused.
            if (state == EXEC) begin
                cnt <= cnt + ONE_V;
            end
            if (cnt_hit) begin
                result_r <= bus.result;
                status_r <= bus.status;
            end
            // The round-robin pointer moves only when a response is taken,
            // so an aborted or stalled operation does not change priority.
            if (rsp_take) begin
                last <= gsel;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = (state == RESP) ? idx_to_onehot(gsel) : 2'b00;
    assign bus.rsp_result = result_r;
    assign bus.rsp_status = status_r;
    assign bus.oper       = oper_r;
    assign bus.arg_a      = arg_a_r;
    assign bus.arg_b      = arg_b_r;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_exe_sched_w1.sv
// -----------------------------------------------------------------------------
// tb_exe_sched_w1
// Directed bench for exe_sched_w1. Three schedulers (LAT = 1, 3, 4) each sit
// next to a stub execution unit whose output is argA^argB / oper delayed by
// LAT registers. One shared stimulus/observation port is routed to the
// scheduler selected by sel. Expected responses are queued when a request
// is accepted and compared when the scheduler answers.
// -----------------------------------------------------------------------------
module tb_exe_sched_w1;
    import exe_sched_pkg::*;

    typedef struct {
        logic [1:0] vld;
        logic [3:0] res;
        logic [1:0] st;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    int              sel;
    int              n_tests = 0;
    int              n_fail  = 0;
    exp_t            sbq[$];

    logic [1:0]      req_valid;
    logic [1:0]      rsp_ready;
    logic [1:0][1:0] req_oper;
    logic [1:0][3:0] req_a;
    logic [1:0][3:0] req_b;

    logic [1:0]      o_req_ready;
    logic [1:0]      o_rsp_valid;
    logic [3:0]      o_res;
    logic [1:0]      o_st;
    logic [1:0]      o_oper;
    logic [3:0]      o_arga;
    logic [3:0]      o_argb;
    logic            o_busy;

    exe_sched_w1_if #(.M(4), .N(2)) bl1 ();
    exe_sched_w1_if #(.M(4), .N(2)) bl3 ();
    exe_sched_w1_if #(.M(4), .N(2)) bl4 ();

    exe_sched_w1 #(.M(4), .N(2), .LAT(1)) u_lat1 (.i_clk(clk), .i_rst(rst), .bus(bl1.slave));
    exe_sched_w1 #(.M(4), .N(2), .LAT(3)) u_lat3 (.i_clk(clk), .i_rst(rst), .bus(bl3.slave));
    exe_sched_w1 #(.M(4), .N(2), .LAT(4)) u_lat4 (.i_clk(clk), .i_rst(rst), .bus(bl4.slave));

    assign bl1.req_valid = (sel == 0) ? req_valid : 2'b00;
    assign bl3.req_valid = (sel == 1) ? req_valid : 2'b00;
    assign bl4.req_valid = (sel == 2) ? req_valid : 2'b00;
    assign bl1.rsp_ready = (sel == 0) ? rsp_ready : 2'b00;
    assign bl3.rsp_ready = (sel == 1) ? rsp_ready : 2'b00;
    assign bl4.rsp_ready = (sel == 2) ? rsp_ready : 2'b00;
    assign bl1.req_oper  = req_oper;
    assign bl3.req_oper  = req_oper;
    assign bl4.req_oper  = req_oper;
    assign bl1.req_arg_a = req_a;
    assign bl3.req_arg_a = req_a;
    assign bl4.req_arg_a = req_a;
    assign bl1.req_arg_b = req_b;
    assign bl3.req_arg_b = req_b;
    assign bl4.req_arg_b = req_b;

    // Stub execution units
    logic [3:0] r1;
    logic [1:0] s1;
    logic [3:0] r3[3];
    logic [1:0] s3[3];
    logic [3:0] r4[4];
    logic [1:0] s4[4];

    always_ff @(posedge clk) begin
        r1    <= bl1.arg_a ^ bl1.arg_b;
        s1    <= bl1.oper;
        r3[0] <= bl3.arg_a ^ bl3.arg_b;
        s3[0] <= bl3.oper;
        r3[1] <= r3[0];
        s3[1] <= s3[0];
        r3[2] <= r3[1];
        s3[2] <= s3[1];
        r4[0] <= bl4.arg_a ^ bl4.arg_b;
        s4[0] <= bl4.oper;
        r4[1] <= r4[0];
        s4[1] <= s4[0];
        r4[2] <= r4[1];
        s4[2] <= s4[1];
        r4[3] <= r4[2];
        s4[3] <= s4[2];
    end

    assign bl1.result = r1;
    assign bl1.status = s1;
    assign bl3.result = r3[2];
    assign bl3.status = s3[2];
    assign bl4.result = r4[3];
    assign bl4.status = s4[3];

    always_comb begin
        o_req_ready = bl1.req_ready;
        o_rsp_valid = bl1.rsp_valid;
        o_res       = bl1.rsp_result;
        o_st        = bl1.rsp_status;
        o_oper      = bl1.oper;
        o_arga      = bl1.arg_a;
        o_argb      = bl1.arg_b;
        o_busy      = bl1.busy;
        if (sel == 1) begin
            o_req_ready = bl3.req_ready;
            o_rsp_valid = bl3.rsp_valid;
            o_res       = bl3.rsp_result;
            o_st        = bl3.rsp_status;
            o_oper      = bl3.oper;
            o_arga      = bl3.arg_a;
            o_argb      = bl3.arg_b;
            o_busy      = bl3.busy;
        end else if (sel == 2) begin
            o_req_ready = bl4.req_ready;
            o_rsp_valid = bl4.rsp_valid;
            o_res       = bl4.rsp_result;
            o_st        = bl4.rsp_status;
            o_oper      = bl4.oper;
            o_arga      = bl4.arg_a;
            o_argb      = bl4.arg_b;
            o_busy      = bl4.busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents a request in an IDLE cycle and expects immediate acceptance.
    task automatic issue(input int c, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        req_oper[c]  = op;
        req_a[c]     = a;
        req_b[c]     = b;
        req_valid[c] = 1'b1;
        #1;
        check($sformatf("accept_c%0d", c), o_req_ready, idx_to_onehot(c[0]));
        e.vld = idx_to_onehot(c[0]);
        e.res = a ^ b;
        e.st  = op;
        sbq.push_back(e);
    endtask

    // Waits (bounded) for a response, compares it with the queue head,
    // completes the handshake and checks the return to IDLE.
    task automatic serve_resp(input string tag, input int budget);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (o_rsp_valid === 2'b00 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, sbq.size(), 1);
            e.vld = 2'b11;
        end else begin
            e = sbq.pop_front();
            check({tag, "_rsp_valid"}, o_rsp_valid, e.vld);
            check({tag, "_result"}, o_res, e.res);
            check({tag, "_status"}, o_st, e.st);
        end
        rsp_ready = e.vld;
        @(negedge clk);
        rsp_ready = 2'b00;
        check({tag, "_idle_busy"}, o_busy, 1'b0);
        check({tag, "_idle_rsp_valid"}, o_rsp_valid, 2'b00);
    endtask

    // One request with exact latency and operand-stability checks.
    task automatic run_single(input string tag, input int c, input logic [1:0] op,
                              input logic [3:0] a, input logic [3:0] b, input int lat);
        issue(c, op, a, b);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) req_valid[c] = 1'b0;
            check($sformatf("%s_oper_t%0d", tag, k), o_oper, op);
            check($sformatf("%s_arga_t%0d", tag, k), o_arga, a);
            check($sformatf("%s_argb_t%0d", tag, k), o_argb, b);
            check($sformatf("%s_novld_t%0d", tag, k), o_rsp_valid, 2'b00);
            check($sformatf("%s_busy_t%0d", tag, k), o_busy, 1'b1);
        end
        serve_resp(tag, 0);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst       = 1'b1;
        sel       = 0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_oper  = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset values on every instance
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("rst%0d_req_ready", s), o_req_ready, 2'b00);
            check($sformatf("rst%0d_rsp_valid", s), o_rsp_valid, 2'b00);
            check($sformatf("rst%0d_result", s), o_res, 4'h0);
            check($sformatf("rst%0d_status", s), o_st, 2'b00);
            check($sformatf("rst%0d_oper", s), o_oper, 2'b00);
            check($sformatf("rst%0d_arga", s), o_arga, 4'h0);
            check($sformatf("rst%0d_argb", s), o_argb, 4'h0);
            check($sformatf("rst%0d_busy", s), o_busy, 1'b0);
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single request, LAT=1
        run_single("single", 0, 2'd2, 4'hF, 4'hD, 1);

        // Tie arbitration from reset: grants 0, 1, 0, 1
        apply_reset();
        req_oper[1]  = 2'd3;
        req_a[1]     = 4'hA;
        req_b[1]     = 4'h6;
        req_valid[1] = 1'b1;
        issue(0, 2'd1, 4'h3, 4'h5);
        @(negedge clk);
        req_valid[0] = 1'b0;
        serve_resp("tie_r1", 20);
        req_oper[0]  = 2'd2;
        req_a[0]     = 4'h8;
        req_b[0]     = 4'h1;
        req_valid[0] = 1'b1;
        issue(1, 2'd3, 4'hA, 4'h6);
        @(negedge clk);
        req_oper[1] = 2'd0;
        req_a[1]    = 4'h5;
        req_b[1]    = 4'h5;
        serve_resp("tie_r2", 20);
        issue(0, 2'd2, 4'h8, 4'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        serve_resp("tie_r3", 20);
        issue(1, 2'd0, 4'h5, 4'h5);
        @(negedge clk);
        req_valid = 2'b00;
        serve_resp("tie_r4", 20);

        // Response backpressure with the other client waiting
        issue(1, 2'd1, 4'h9, 4'h3);
        @(negedge clk);
        req_valid[1] = 1'b0;
        n = 0;
        while (o_rsp_valid === 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = sbq.pop_front();
        check("bp_rsp_valid", o_rsp_valid, e.vld);
        check("bp_result", o_res, e.res);
        check("bp_status", o_st, e.st);
        req_oper[0]  = 2'd0;
        req_a[0]     = 4'h7;
        req_b[0]     = 4'h7;
        req_valid[0] = 1'b1;
        rsp_ready    = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold_vld%0d", k), o_rsp_valid, e.vld);
            check($sformatf("bp_hold_res%0d", k), o_res, e.res);
            check($sformatf("bp_hold_st%0d", k), o_st, e.st);
            check($sformatf("bp_hold_rdy%0d", k), o_req_ready, 2'b00);
            check($sformatf("bp_hold_busy%0d", k), o_busy, 1'b1);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        check("bp_release_busy", o_busy, 1'b0);
        issue(0, 2'd0, 4'h7, 4'h7);
        @(negedge clk);
        req_valid = 2'b00;
        serve_resp("bp_c0", 20);

        // Asynchronous reset in EXEC, LAT=3
        sel = 1;
        apply_reset();
        issue(0, 2'd3, 4'h6, 4'h5);
        sbq.delete();
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", o_busy, 1'b0);
        check("abort_oper", o_oper, 2'b00);
        check("abort_arga", o_arga, 4'h0);
        check("abort_argb", o_argb, 4'h0);
        check("abort_rsp_valid", o_rsp_valid, 2'b00);
        check("abort_req_ready", o_req_ready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("abort_norsp%0d", k), o_rsp_valid, 2'b00);
        end
        run_single("post_abort", 1, 2'd1, 4'hC, 4'h3, 3);
        req_oper[1]  = 2'd2;
        req_a[1]     = 4'h1;
        req_b[1]     = 4'h1;
        req_valid[1] = 1'b1;
        issue(0, 2'd1, 4'h2, 4'h4);
        @(negedge clk);
        req_valid = 2'b00;
        serve_resp("post_abort_tie", 20);

        // Latency sweep, LAT=4
        sel = 2;
        @(negedge clk);
        run_single("lat4", 0, 2'd2, 4'hF, 4'hD, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
